step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer_if.sv | 24 ++
 rtl/step_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_step_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/step_sequencer_if.sv
// Keyboard byte stream in, LED and 7-segment display drive out.
// Latency: none (bundle of wires only).
// Backpressure: none; bytes are presented as one-cycle strobes.
interface step_sequencer_if;
   logic [8:0] sim_data;
   logic       sim_data_en;
   logic [9:0] LEDR;
   logic [6:0] HEX0;
   logic [6:0] HEX1;
   logic [6:0] HEX2;
   logic [6:0] HEX3;
   logic [6:0] HEX4;
   logic [6:0] HEX5;

   modport master (
      output sim_data, sim_data_en,
      input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
   );

   modport slave (
      input  sim_data, sim_data_en,
      output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
   );
endinterface

// File: rtl/step_sequencer.sv
// 16-step sequencer controlled by PS/2 scan codes, with BPM/length entry and 7-seg readout.
// Latency: a key takes effect on the clock edge that samples it; displays are combinational from registers.
// Backpressure: none; every strobed byte is consumed (or discarded) in its own cycle.
module step_sequencer #(
   parameter int unsigned STEP_THRESH = 750000000
) (
   input  logic          CLOCK_50,
   input  logic [2:0]    KEY,
   step_sequencer_if.slave io_sq
);

   typedef enum logic [1:0] {ST_IDLE, ST_BPM, ST_LEN} state_t;

   localparam int ACC_W = 32;
   localparam logic [ACC_W-1:0] THRESH = ACC_W'(STEP_THRESH);

   localparam logic [7:0] KC_B     = 8'h32;
   localparam logic [7:0] KC_L     = 8'h4B;
   localparam logic [7:0] KC_M     = 8'h3A;
   localparam logic [7:0] KC_SPACE = 8'h29;
   localparam logic [7:0] KC_T     = 8'h2C;
   localparam logic [7:0] KC_ENTER = 8'h5A;
   localparam logic [7:0] KC_ESC   = 8'h76;
   localparam logic [7:0] KC_BREAK = 8'hF0;
   localparam logic [7:0] KC_EXT   = 8'hE0;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_L     = 7'h47;

   // Active-low 7-segment encoding, bit0 = a ... bit6 = g.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   logic w_rst_n;
   logic w_unused;
   assign w_rst_n  = KEY[0];
   assign w_unused = ^KEY[2:1];

   // Architectural state
   state_t           r_state;
   logic [9:0]       r_bpm;
   logic [4:0]       r_len;
   logic [3:0]       r_step;
   logic [ACC_W-1:0] r_acc;
   logic             r_playing;
   logic             r_mute;
   logic [15:0]      r_pattern;
   logic [9:0]       r_buf;
   logic [1:0]       r_cnt;
   logic             r_f0;

   // Next-state values
   state_t           w_nxt_state;
   logic [9:0]       w_nxt_bpm;
   logic [4:0]       w_nxt_len;
   logic [3:0]       w_nxt_step;
   logic [ACC_W-1:0] w_nxt_acc;
   logic             w_nxt_playing;
   logic             w_nxt_mute;
   logic [15:0]      w_nxt_pattern;
   logic [9:0]       w_nxt_buf;
   logic [1:0]       w_nxt_cnt;
   logic             w_nxt_f0;

   logic [7:0]       w_code;
   logic             w_strobe;
   logic             w_key_vld;
   logic             w_dig_vld;
   logic [3:0]       w_dig;
   logic [ACC_W-1:0] w_acc_sum;
   logic [3:0]       w_step_adv;
   logic [9:0]       w_buf_shift;

   // Break-flagged bytes never reach the controller; E0 and F0-plus-next are dropped too.
   assign w_code    = io_sq.sim_data[7:0];
   assign w_strobe  = io_sq.sim_data_en & ~io_sq.sim_data[8];
   assign w_key_vld = w_strobe & ~r_f0 & (w_code != KC_BREAK) & (w_code != KC_EXT);

   assign w_acc_sum   = r_acc + ACC_W'(r_bpm);
   assign w_step_adv  = ({1'b0, r_step} == (r_len - 5'd1)) ? 4'd0 : (r_step + 4'd1);
   assign w_buf_shift = (r_buf * 10'd10) + {6'd0, w_dig};

   // Scan code to decimal digit
   always_comb begin
      w_dig_vld = 1'b1;
      w_dig     = 4'd0;
      case (w_code)
         8'h45:   w_dig = 4'd0;
         8'h16:   w_dig = 4'd1;
         8'h1E:   w_dig = 4'd2;
         8'h26:   w_dig = 4'd3;
         8'h25:   w_dig = 4'd4;
         8'h2E:   w_dig = 4'd5;
         8'h36:   w_dig = 4'd6;
         8'h3D:   w_dig = 4'd7;
         8'h3E:   w_dig = 4'd8;
         8'h46:   w_dig = 4'd9;
         default: w_dig_vld = 1'b0;
      endcase
   end

   // Controller next-state: tempo accumulator first, then key actions override it
   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_bpm     = r_bpm;
      w_nxt_len     = r_len;
      w_nxt_step    = r_step;
      w_nxt_acc     = r_acc;
      w_nxt_playing = r_playing;
      w_nxt_mute    = r_mute;
      w_nxt_pattern = r_pattern;
      w_nxt_buf     = r_buf;
      w_nxt_cnt     = r_cnt;
      w_nxt_f0      = r_f0;

      if (r_playing) begin
         if (w_acc_sum >= THRESH) begin
            w_nxt_acc  = w_acc_sum - THRESH;
            w_nxt_step = w_step_adv;
         end else begin
            w_nxt_acc = w_acc_sum;
         end
      end

      if (w_strobe) begin
         if (r_f0) begin
            w_nxt_f0 = 1'b0;
         end else if (w_code == KC_BREAK) begin
            w_nxt_f0 = 1'b1;
         end
      end

      if (w_key_vld) begin
         case (r_state)
            ST_IDLE: begin
               case (w_code)
                  KC_B: begin
                     w_nxt_state = ST_BPM;
                     w_nxt_buf   = '0;
                     w_nxt_cnt   = '0;
                  end
                  KC_L: begin
                     w_nxt_state = ST_LEN;
                     w_nxt_buf   = '0;
                     w_nxt_cnt   = '0;
                  end
                  KC_M: w_nxt_mute = ~r_mute;
                  KC_SPACE: begin
                     if (r_playing) begin
                        // Stopping freezes position so a restart can be compared against it.
                        w_nxt_playing = 1'b0;
                        w_nxt_acc     = r_acc;
                        w_nxt_step    = r_step;
                     end else begin
                        w_nxt_playing = 1'b1;
                        w_nxt_acc     = '0;
                     end
                  end
                  KC_T:     w_nxt_pattern = r_pattern ^ (16'd1 << r_step);
                  KC_ENTER: w_nxt_step    = '0;
                  default: ;
               endcase
            end
            ST_BPM, ST_LEN: begin
               if (w_dig_vld) begin
                  if (r_cnt != 2'd3) begin
                     w_nxt_buf = w_buf_shift;
                     w_nxt_cnt = r_cnt + 2'd1;
                  end
               end else if (w_code == KC_ESC) begin
                  w_nxt_state = ST_IDLE;
               end else if (w_code == KC_ENTER) begin
                  w_nxt_state = ST_IDLE;
                  if (r_state == ST_BPM) begin
                     if (r_buf != 10'd0) begin
                        w_nxt_bpm = r_buf;
                     end
                  end else if ((r_buf != 10'd0) && (r_buf <= 10'd16)) begin
                     w_nxt_len = r_buf[4:0];
                     // Keep the playhead inside the new pattern length.
                     if ({1'b0, w_nxt_step} >= r_buf[4:0]) begin
                        w_nxt_step = '0;
                     end
                  end
               end
            end
            default: w_nxt_state = ST_IDLE;
         endcase
      end
   end

   // State register with asynchronous reset from KEY[0]
   always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state   <= ST_IDLE;
         r_bpm     <= 10'd120;
         r_len     <= 5'd16;
         r_step    <= '0;
         r_acc     <= '0;
         r_playing <= 1'b0;
         r_mute    <= 1'b0;
         r_pattern <= 16'hFFFF;
         r_buf     <= '0;
         r_cnt     <= '0;
         r_f0      <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_bpm     <= w_nxt_bpm;
         r_len     <= w_nxt_len;
         r_step    <= w_nxt_step;
         r_acc     <= w_nxt_acc;
         r_playing <= w_nxt_playing;
         r_mute    <= w_nxt_mute;
         r_pattern <= w_nxt_pattern;
         r_buf     <= w_nxt_buf;
         r_cnt     <= w_nxt_cnt;
         r_f0      <= w_nxt_f0;
      end
   end

   // Display and LED decode
   logic [9:0] w_disp_val;
   logic [3:0] w_hund;
   logic [3:0] w_tens;
   logic [3:0] w_units;
   logic [4:0] w_step_p1;
   logic       w_step_tens;
   logic [3:0] w_step_units;
   logic       w_gate;

   assign w_disp_val   = (r_state == ST_IDLE) ? r_bpm : r_buf;
   assign w_hund       = 4'(w_disp_val / 10'd100);
   assign w_tens       = 4'((w_disp_val / 10'd10) % 10'd10);
   assign w_units      = 4'(w_disp_val % 10'd10);
   assign w_step_p1    = {1'b0, r_step} + 5'd1;
   assign w_step_tens  = (w_step_p1 >= 5'd10);
   assign w_step_units = 4'(w_step_tens ? (w_step_p1 - 5'd10) : w_step_p1);
   assign w_gate       = r_playing & ~r_mute & r_pattern[r_step];

   // Seven-segment and LED output mapping with leading-zero blanking
   always_comb begin
      io_sq.LEDR = {r_playing, r_mute, w_gate, 2'b00, r_pattern[r_step], r_step};
      io_sq.HEX0 = seg7(w_units);
      io_sq.HEX1 = ((w_hund == 4'd0) && (w_tens == 4'd0)) ? SEG_BLANK : seg7(w_tens);
      io_sq.HEX2 = (w_hund == 4'd0) ? SEG_BLANK : seg7(w_hund);
      io_sq.HEX3 = SEG_BLANK;
      if (r_state == ST_BPM) begin
         io_sq.HEX3 = SEG_B;
      end else if (r_state == ST_LEN) begin
         io_sq.HEX3 = SEG_L;
      end
      io_sq.HEX4 = seg7(w_step_units);
      io_sq.HEX5 = w_step_tens ? seg7(4'd1) : SEG_BLANK;
   end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with a short step threshold.
// Latency: drives on falling edges, samples on falling edges.
// Backpressure: n/a.
module tb_step_sequencer;

   localparam logic [6:0] S0 = 7'h40;
   localparam logic [6:0] S1 = 7'h79;
   localparam logic [6:0] S2 = 7'h24;
   localparam logic [6:0] S4 = 7'h19;
   localparam logic [6:0] S5 = 7'h12;
   localparam logic [6:0] S9 = 7'h10;
   localparam logic [6:0] SB = 7'h7F;
   localparam logic [6:0] SLB = 7'h03;
   localparam logic [6:0] SLL = 7'h47;

   logic       clk;
   logic [2:0] key;
   int         n_checks;
   int         n_fail;
   logic [3:0] exp_steps [0:12];

   step_sequencer_if u_if ();

   step_sequencer #(.STEP_THRESH(2000)) dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .io_sq    (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [8:0] d);
      @(negedge clk);
      u_if.sim_data    = d;
      u_if.sim_data_en = 1'b1;
      @(negedge clk);
      u_if.sim_data_en = 1'b0;
      u_if.sim_data    = '0;
   endtask

   task automatic chk_num(input string tag, input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
      chk({tag, "_hex2"}, {25'd0, u_if.HEX2}, {25'd0, h2});
      chk({tag, "_hex1"}, {25'd0, u_if.HEX1}, {25'd0, h1});
      chk({tag, "_hex0"}, {25'd0, u_if.HEX0}, {25'd0, h0});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_steps = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0, 4'd1, 4'd1};
      u_if.sim_data    = '0;
      u_if.sim_data_en = 1'b0;
      key = 3'b110;
      repeat (3) @(negedge clk);
      key = 3'b111;
      @(negedge clk);

      // Reset state
      chk("rst_ledr", {22'd0, u_if.LEDR}, 32'h010);
      chk_num("rst_bpm", S1, S2, S0);
      chk("rst_hex3", {25'd0, u_if.HEX3}, {25'd0, SB});
      chk("rst_hex5", {25'd0, u_if.HEX5}, {25'd0, SB});
      chk("rst_hex4", {25'd0, u_if.HEX4}, {25'd0, S1});

      // BPM entry: b 9 9 9 (extra 5 ignored) Enter
      send(9'h032);
      chk("bpm_ent_hex3", {25'd0, u_if.HEX3}, {25'd0, SLB});
      chk_num("bpm_ent_empty", SB, SB, S0);
      send(9'h046);
      send(9'h046);
      chk_num("bpm_ent_99", SB, S9, S9);
      send(9'h046);
      send(9'h02E);
      chk_num("bpm_ent_999", S9, S9, S9);
      send(9'h05A);
      chk("bpm_commit_hex3", {25'd0, u_if.HEX3}, {25'd0, SB});
      chk_num("bpm_commit", S9, S9, S9);

      // Break handling
      send(9'h0F0);
      send(9'h032);
      chk("brk_f0_b", {25'd0, u_if.HEX3}, {25'd0, SB});
      send(9'h132);
      chk("brk_bit8_b", {25'd0, u_if.HEX3}, {25'd0, SB});
      send(9'h032);
      chk("after_brk_b", {25'd0, u_if.HEX3}, {25'd0, SLB});
      send(9'h076);
      chk("esc_hex3", {25'd0, u_if.HEX3}, {25'd0, SB});

      // Rejected BPM values
      send(9'h032);
      send(9'h045);
      send(9'h05A);
      chk_num("bpm_zero_kept", S9, S9, S9);
      send(9'h032);
      send(9'h02E);
      chk_num("bpm_ent_5", SB, SB, S5);
      send(9'h076);
      chk("bpm_esc_hex3", {25'd0, u_if.HEX3}, {25'd0, SB});
      chk_num("bpm_esc_kept", S9, S9, S9);

      // len=1, then rejected lengths 20 and 0, then play
      send(9'h04B);
      send(9'h016);
      send(9'h05A);
      send(9'h04B);
      send(9'h01E);
      send(9'h045);
      chk("len_ent_hex3", {25'd0, u_if.HEX3}, {25'd0, SLL});
      chk_num("len_ent_20", SB, S2, S0);
      send(9'h05A);
      send(9'h04B);
      send(9'h045);
      send(9'h05A);
      send(9'h029);
      repeat (6) @(negedge clk);
      chk("play_len1_ledr", {22'd0, u_if.LEDR}, 32'h290);

      // Mute and stop
      send(9'h03A);
      chk("mute_ledr", {22'd0, u_if.LEDR}, 32'h310);
      send(9'h029);
      chk("stop_muted_ledr", {22'd0, u_if.LEDR}, 32'h110);
      send(9'h03A);
      chk("unmute_ledr", {22'd0, u_if.LEDR}, 32'h010);

      // len=4, bpm=999: step timing from Space
      send(9'h04B);
      send(9'h025);
      send(9'h05A);
      send(9'h029);
      for (int i = 0; i < 13; i++) begin
         chk($sformatf("step_t%0d", i), {28'd0, u_if.LEDR[3:0]}, {28'd0, exp_steps[i]});
         if (i == 7) begin
            chk("hex4_step4", {25'd0, u_if.HEX4}, {25'd0, S4});
            chk("hex5_step4", {25'd0, u_if.HEX5}, {25'd0, SB});
         end
         if (i < 12) @(negedge clk);
      end
      // Stop on a cycle that would otherwise advance
      u_if.sim_data    = 9'h029;
      u_if.sim_data_en = 1'b1;
      @(negedge clk);
      u_if.sim_data_en = 1'b0;
      chk("stop_hold_step", {28'd0, u_if.LEDR[3:0]}, 32'd1);
      chk("stop_playing", {31'd0, u_if.LEDR[9]}, 32'd0);
      repeat (4) @(negedge clk);
      chk("stopped_step", {28'd0, u_if.LEDR[3:0]}, 32'd1);

      // Restart clears acc: next advance is three cycles later
      send(9'h029);
      chk("restart_t0", {28'd0, u_if.LEDR[3:0]}, 32'd1);
      repeat (2) @(negedge clk);
      chk("restart_t2", {28'd0, u_if.LEDR[3:0]}, 32'd1);
      @(negedge clk);
      chk("restart_t3", {28'd0, u_if.LEDR[3:0]}, 32'd2);
      chk("restart_playing", {31'd0, u_if.LEDR[9]}, 32'd1);

      // Stop, Enter to step 0, toggle pattern bit
      send(9'h029);
      send(9'h05A);
      chk("enter_step0", {22'd0, u_if.LEDR}, 32'h010);
      send(9'h02C);
      chk("toggle_pat", {22'd0, u_if.LEDR}, 32'h000);

      // Reset in the middle of an entry
      send(9'h032);
      send(9'h02E);
      chk("pre_rst_hex0", {25'd0, u_if.HEX0}, {25'd0, S5});
      @(negedge clk);
      key = 3'b110;
      #1;
      chk("midrst_hex3", {25'd0, u_if.HEX3}, {25'd0, SB});
      chk_num("midrst_bpm", S1, S2, S0);
      chk("midrst_ledr", {22'd0, u_if.LEDR}, 32'h010);
      repeat (2) @(negedge clk);
      key = 3'b111;
      repeat (2) @(negedge clk);
      chk_num("postrst_bpm", S1, S2, S0);
      chk("postrst_hex3", {25'd0, u_if.HEX3}, {25'd0, SB});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
